// File: rtl/sevenseg_scan_mux_if.sv
// sevenseg_scan_mux_if: value/control inputs and display drive outputs of the 7-segment scan mux.
interface sevenseg_scan_mux_if;
    logic [31:0] value_in;
    logic [7:0]  dp_in;
    logic        load;
    logic [7:0]  digit_en;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output value_in, dp_in, load, digit_en, blank_lz,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  value_in, dp_in, load, digit_en, blank_lz,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/sevenseg_scan_mux.sv
// sevenseg_scan_mux: 8-digit time-multiplexed 7-segment driver with frame-synchronous double buffering,
// per-digit enable/dp, leading-zero blanking and a dark dead time at the start of each slot.
module sevenseg_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input logic                clk_in,
    input logic                reset_n,
    sevenseg_scan_mux_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [31:0]   shadow_val, disp_val;
    logic [7:0]    shadow_dp, disp_dp;
    logic          pending, wrap, commit, lz, lit;
    logic [7:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    // lz: this digit and every digit to its left hold zero
    always_comb begin
        wrap     = presc == PW'(REFRESH_DIV - 1);
        commit   = wrap && idx == 3'd7;
        lz       = bus.blank_lz && idx != 3'd0 && (disp_val >> {idx, 2'b00}) == 32'd0;
        lit      = presc >= PW'(BLANK_CYCLES) && bus.digit_en[idx] && !lz;
        an_next  = lit ? ~(8'd1 << idx) : 8'hFF;
        seg_next = lit ? HEX[disp_val[{idx, 2'b00} +: 4]] : 7'h7F;
        dp_next  = lit ? ~disp_dp[idx] : 1'b1;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            presc          <= '0;
            idx            <= '0;
            shadow_val     <= '0;
            shadow_dp      <= '0;
            disp_val       <= '0;
            disp_dp        <= '0;
            pending        <= 1'b0;
            bus.an         <= 8'hFF;
            bus.seg        <= 7'h7F;
            bus.dp         <= 1'b1;
            bus.frame_tick <= 1'b0;
        end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            if (wrap)
                idx <= idx + 3'd1;
            if (bus.load) begin
                shadow_val <= bus.value_in;
                shadow_dp  <= bus.dp_in;
            end
            // a load landing on the commit cycle bypasses the shadow
            if (commit) begin
                if (bus.load) begin
                    disp_val <= bus.value_in;
                    disp_dp  <= bus.dp_in;
                end else if (pending) begin
                    disp_val <= shadow_val;
                    disp_dp  <= shadow_dp;
                end
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
            bus.frame_tick <= commit;
            bus.an         <= an_next;
            bus.seg        <= seg_next;
            bus.dp         <= dp_next;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// tb_sevenseg_scan_mux: directed and randomized checks of the scan mux against a cycle-count based model.
module tb_sevenseg_scan_mux;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int FRAME = RD * 8;

    logic clk_in = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    sevenseg_scan_mux_if bus();

    sevenseg_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // model: elapsed cycles since reset release plus the frame-buffer contents
    int          t;
    logic [31:0] m_disp, m_sh;
    logic [7:0]  m_dpd, m_shdp;
    bit          m_pend;
    logic [7:0]  e_an = 8'hFF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic        e_ft = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".an"}, {24'd0, bus.an}, {24'd0, e_an});
        check({tag, ".seg"}, {25'd0, bus.seg}, {25'd0, e_seg});
        check({tag, ".dp"}, {31'd0, bus.dp}, {31'd0, e_dp});
        check({tag, ".frame_tick"}, {31'd0, bus.frame_tick}, {31'd0, e_ft});
    endtask

    task automatic model_reset();
        t = 0;
        m_disp = '0;
        m_dpd = '0;
        m_sh = '0;
        m_shdp = '0;
        m_pend = 0;
        e_an = 8'hFF;
        e_seg = 7'h7F;
        e_dp = 1'b1;
        e_ft = 1'b0;
    endtask

    task automatic step();
        int slot_pos, digit, nib;
        bit dark;
        @(posedge clk_in);
        slot_pos = t % RD;
        digit = (t / RD) % 8;
        nib = int'((m_disp >> (4 * digit)) & 32'hF);
        dark = slot_pos < BC || !bus.digit_en[digit] ||
               (bus.blank_lz && digit > 0 && (m_disp >> (4 * digit)) == 32'd0);
        e_an = dark ? 8'hFF : ~(8'd1 << digit);
        e_seg = dark ? 7'h7F : hex_tab[nib];
        e_dp = dark ? 1'b1 : ~m_dpd[digit];
        e_ft = (t % FRAME) == FRAME - 1;
        if (e_ft) begin
            if (bus.load) begin
                m_disp = bus.value_in;
                m_dpd = bus.dp_in;
            end else if (m_pend) begin
                m_disp = m_sh;
                m_dpd = m_shdp;
            end
            m_pend = 0;
        end else if (bus.load) begin
            m_sh = bus.value_in;
            m_shdp = bus.dp_in;
            m_pend = 1;
        end
        t++;
        @(negedge clk_in);
        check_outputs("scan");
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] d);
        bus.value_in = v;
        bus.dp_in = d;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic run_to_phase(input int ph);
        for (int k = 0; k < FRAME && (t % FRAME) != ph; k++) step();
    endtask

    initial begin
        bus.value_in = '0;
        bus.dp_in = '0;
        bus.load = 1'b0;
        bus.digit_en = 8'hFF;
        bus.blank_lz = 1'b0;
        model_reset();
        repeat (4) begin
            @(negedge clk_in);
            bus.value_in = $urandom;
            bus.load = 1'b1;
            check_outputs("reset");
        end
        bus.load = 1'b0;
        bus.value_in = '0;
        @(negedge clk_in);
        reset_n = 1'b1;
        model_reset();
        run(40);

        do_load(32'h89ABCDEF, 8'h00);
        run(70);

        bus.blank_lz = 1'b1;
        do_load(32'h000000A5, 8'h00);
        run(70);
        bus.blank_lz = 1'b0;
        run(40);

        bus.blank_lz = 1'b1;
        do_load(32'h00000000, 8'h00);
        run(40);
        bus.digit_en = 8'hFE;
        run(40);
        bus.digit_en = 8'hFF;

        run_to_phase(5);
        do_load(32'h11111111, 8'h00);
        run_to_phase(20);
        do_load(32'h22222222, 8'h00);
        run(70);
        run_to_phase(FRAME - 1);
        do_load(32'h33333333, 8'h00);
        run(40);

        do_load(32'h00000100, 8'h04);
        run(70);

        for (int k = 0; k < 16 && e_an == 8'hFF; k++) step();
        #2 reset_n = 1'b0;
        #1;
        e_an = 8'hFF;
        e_seg = 7'h7F;
        e_dp = 1'b1;
        e_ft = 1'b0;
        check_outputs("async_reset");
        @(negedge clk_in);
        check_outputs("async_reset_hold");
        reset_n = 1'b1;
        model_reset();
        run(40);

        for (int k = 0; k < 2000; k++) begin
            bus.value_in = $urandom >> $urandom_range(31);
            bus.dp_in = 8'($urandom);
            bus.load = $urandom_range(7) == 0;
            if ($urandom_range(63) == 0) bus.digit_en = ($urandom_range(1) == 0) ? 8'hFF : 8'($urandom);
            if ($urandom_range(31) == 0) bus.blank_lz = ~bus.blank_lz;
            step();
        end
        bus.load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan_mux.md
Name: sevenseg_scan_mux

Overview:
- Downstream display stage for the counter/datapath blocks: accepts an 8-nibble hex value and drives all eight anodes of the board's 7-segment display by time multiplexing.
- Replaces the single-digit, anode-0-only driving with a full scan.
- Provides frame-synchronous double buffering so the counter can update at any time without tearing.
- Supports per-digit enable, per-digit decimal point, leading-zero blanking and an anti-ghosting dead time.

Parameters:
- REFRESH_DIV, 100000, clk_in cycles per digit slot (1 kHz per digit, 125 Hz frame at 100 MHz); must be >= 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk_in  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- value_in  in  32  hex value; nibble i is shown on digit i (digit 0 = rightmost).
- dp_in  in  8  decimal point request per digit, 1 = lit.
- load  in  1  capture value_in/dp_in into the shadow register this cycle.
- digit_en  in  8  1 = digit may light; sampled live, not buffered.
- blank_lz  in  1  1 = suppress leading zeros; sampled live.
- an  out  8  anode drive, active-low.
- seg  out  7  segments, active-low; bit6 = CA … bit0 = CG.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse at each frame commit.

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0, digit index = 0.
  - shadow value/dp = 0, display value/dp = 0, pending = 0.
  - Outputs: an = 8'hFF, seg = 7'h7F, dp = 1, frame_tick = 0.
  - Reset mid-frame discards any pending load.
- Prescaler: counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, index advances mod 8 (7 -> 0).
- Load:
  - load = 1 copies value_in/dp_in to shadow and sets pending.
  - Multiple loads within a frame: last one wins.
- Commit:
  - Occurs in the cycle where the prescaler wraps and index goes 7 -> 0.
  - If pending, display <= shadow and pending clears.
  - If load is asserted in the commit cycle, display takes value_in/dp_in directly and pending stays 0.
  - frame_tick = 1 in the cycle after each commit point, whether or not pending was set.
- Output registering: an, seg and dp are registered and computed from the prescaler, index and display state of the previous cycle (1-cycle latency).
- Slot timing: while prescaler < BLANK_CYCLES, an = 8'hFF, seg = 7'h7F, dp = 1.
- Active portion of a slot, for current index i:
  - If digit i is blanked: an = 8'hFF, seg = 7'h7F, dp = 1.
  - Otherwise: an = ~(8'b1 << i), seg = hex decode of nibble i, dp = ~dp_disp[i].
- Blanking rules:
  - A digit is blanked if digit_en[i] = 0.
  - A digit is also blanked if blank_lz = 1, i > 0, and nibbles i..7 of the display value are all 0. Digit 0 is never zero-blanked.
  - A digit blanked by leading-zero suppression also suppresses its dp.
- Hex decode (active-low, order a..g), all 16 codes defined:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- No combinational path from any input to any output.

Test Plan (REFRESH_DIV = 4, BLANK_CYCLES = 1):
- Reset held low with value_in changing -> an = FF, seg = 7F, dp = 1, frame_tick = 0. Release; with no load, digit 0 shows 0 (seg = 0000001, an = FE) from cycle 2, active for 3 of every 4 cycles.
- load 0x89ABCDEF, digit_en = FF -> nothing changes until the commit; from the next frame, digit 7 shows 8 (seg 0000000, an = 7F) and digit 0 shows F (seg 0111000, an = FE). frame_tick is high exactly 1 cycle every 32.
- load 0x000000A5, blank_lz = 1 -> digits 2..7 keep an = FF. Digit 1 shows A (0001000), digit 0 shows 5 (0100100). With blank_lz = 0, digits 2..7 show 0.
- value 0, blank_lz = 1 -> digit 0 shows 0, all others dark. digit_en = FE -> all digits dark, dp = 1.
- load 0x11111111 mid-frame, then 0x22222222 in the same frame -> next frame shows all 2s; 1 is never displayed. A load in the commit cycle itself is displayed in the very next frame.
- dp_in = 8'h04 with value 0x00000100, blank_lz = 1 -> dp = 0 only during digit 2's active cycles. Async reset_n pulse mid-slot -> an = FF immediately, without waiting for a clock edge.
